// File: rtl/sdram_scheduler.sv
// Shares one SDRAM command port between refresh, the camera write path and the HDMI read path,
// and keeps the ping-pong frame buffers so that HDMI always scans out the last complete frame.
module sdram_scheduler #(
    parameter int ADDR_WIDTH         = 22,
    parameter int LEVEL_WIDTH        = 10,
    parameter int BURST_LEN          = 8,
    parameter int FRAME_WORDS        = 153600,
    parameter int BUFFER_STRIDE_LOG2 = 18,
    parameter int REFRESH_INTERVAL   = 375,
    parameter int RD_LOW_WM          = 64,
    parameter int RD_HIGH_WM         = 504
) (
    input  logic                   sdram_clk,
    input  logic                   resetn,
    input  logic                   init_done,
    input  logic [LEVEL_WIDTH-1:0] wr_level,
    input  logic                   wr_frame_start,
    input  logic [LEVEL_WIDTH-1:0] rd_level,
    input  logic                   rd_frame_start,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [1:0]             cmd_op,
    output logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic                   cmd_done,
    output logic                   wr_buffer,
    output logic                   rd_buffer,
    output logic                   refresh_overrun
);
    localparam int OFF_W = $clog2(FRAME_WORDS + 1);
    localparam int TMR_W = $clog2(REFRESH_INTERVAL + 1);
    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_WR   = 2'd1;
    localparam logic [1:0] OP_RD   = 2'd2;
    localparam logic [1:0] OP_REF  = 2'd3;
    localparam logic [OFF_W-1:0]       FRAME_END  = OFF_W'(FRAME_WORDS);
    localparam logic [OFF_W-1:0]       BURST      = OFF_W'(BURST_LEN);
    localparam logic [TMR_W-1:0]       TMR_RELOAD = TMR_W'(REFRESH_INTERVAL - 1);
    localparam logic [LEVEL_WIDTH-1:0] LOW_WM     = LEVEL_WIDTH'(RD_LOW_WM);
    localparam logic [LEVEL_WIDTH-1:0] HIGH_WM    = LEVEL_WIDTH'(RD_HIGH_WM);
    localparam logic [LEVEL_WIDTH-1:0] WR_MIN     = LEVEL_WIDTH'(BURST_LEN);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [TMR_W-1:0]       refresh_timer;
    logic [3:0]             refresh_pending;
    logic [OFF_W-1:0]       wr_offset;
    logic [OFF_W-1:0]       rd_offset;
    logic                   frame_complete;
    logic                   wr_suppress;
    logic                   rd_suppress;
    logic [1:0]             pick_op;
    logic [ADDR_WIDTH-1:0]  pick_addr;
    logic [ADDR_WIDTH-1:0]  wr_base;
    logic [ADDR_WIDTH-1:0]  rd_base;
    logic                   launch;
    logic                   finish;
    logic                   refresh_tick;
    logic                   refresh_done;
    logic                   wr_room;
    logic                   rd_room;

    assign wr_room      = (wr_offset < FRAME_END);
    assign rd_room      = (rd_offset < FRAME_END);
    assign wr_base      = ADDR_WIDTH'(wr_buffer) << BUFFER_STRIDE_LOG2;
    assign rd_base      = ADDR_WIDTH'(rd_buffer) << BUFFER_STRIDE_LOG2;
    assign launch       = (state == IDLE) && init_done && (pick_op != OP_NONE);
    assign finish       = (state == BUSY) && cmd_done;
    assign refresh_tick = init_done && (refresh_timer == '0);
    assign refresh_done = finish && (cmd_op == OP_REF);

    // Request arbitration: refresh, urgent read, write, normal read.
    always_comb begin
        pick_op = OP_NONE;
        if (refresh_pending != 4'd0) begin
            pick_op = OP_REF;
        end else if ((rd_level < LOW_WM) && rd_room) begin
            pick_op = OP_RD;
        end else if ((wr_level >= WR_MIN) && wr_room) begin
            pick_op = OP_WR;
        end else if ((rd_level <= HIGH_WM) && rd_room) begin
            pick_op = OP_RD;
        end else begin
            pick_op = OP_NONE;
        end
    end

    // Burst start address for the winning request.
    always_comb begin
        pick_addr = '0;
        case (pick_op)
            OP_WR:   pick_addr = wr_base + ADDR_WIDTH'(wr_offset);
            OP_RD:   pick_addr = rd_base + ADDR_WIDTH'(rd_offset);
            default: pick_addr = '0;
        endcase
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = launch ? ISSUE : IDLE;
            ISSUE:   state_next = cmd_ready ? BUSY : ISSUE;
            BUSY:    state_next = cmd_done ? IDLE : BUSY;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge sdram_clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command registers, held stable while the command is offered.
    always_ff @(posedge sdram_clk or negedge resetn) begin
        if (!resetn) begin
            cmd_valid <= 1'b0;
            cmd_op    <= OP_NONE;
            cmd_addr  <= '0;
        end else if (launch) begin
            cmd_valid <= 1'b1;
            cmd_op    <= pick_op;
            cmd_addr  <= pick_addr;
        end else if ((state == ISSUE) && cmd_ready) begin
            cmd_valid <= 1'b0;
        end else if (finish) begin
            cmd_op    <= OP_NONE;
        end
    end

    // Refresh timer and saturating pending-refresh count.
    always_ff @(posedge sdram_clk or negedge resetn) begin
        if (!resetn) begin
            refresh_timer   <= TMR_RELOAD;
            refresh_pending <= 4'd0;
            refresh_overrun <= 1'b0;
        end else begin
            if (!init_done || (refresh_timer == '0)) begin
                refresh_timer <= TMR_RELOAD;
            end else begin
                refresh_timer <= refresh_timer - TMR_W'(1);
            end
            if (refresh_tick && !refresh_done) begin
                if (refresh_pending == 4'd15) begin
                    refresh_overrun <= 1'b1;
                end else begin
                    refresh_pending <= refresh_pending + 4'd1;
                end
            end else if (refresh_done && !refresh_tick) begin
                refresh_pending <= refresh_pending - 4'd1;
            end
        end
    end

    // Camera side: write offset, buffer toggle and frame completion.
    always_ff @(posedge sdram_clk or negedge resetn) begin
        if (!resetn) begin
            wr_offset      <= '0;
            wr_buffer      <= 1'b0;
            frame_complete <= 1'b0;
            wr_suppress    <= 1'b0;
        end else begin
            if (wr_frame_start) begin
                wr_offset <= '0;
                if (frame_complete) begin
                    wr_buffer      <= ~wr_buffer;
                    frame_complete <= 1'b0;
                end
            end else if (finish && (cmd_op == OP_WR) && !wr_suppress) begin
                wr_offset <= wr_offset + BURST;
                if ((wr_offset + BURST) == FRAME_END) begin
                    frame_complete <= 1'b1;
                end
            end
            // A frame start during the life of a write discards that write's progress.
            if (launch) begin
                wr_suppress <= wr_frame_start;
            end else if (wr_frame_start) begin
                wr_suppress <= 1'b1;
            end
        end
    end

    // HDMI side: read offset and selection of the last complete buffer.
    always_ff @(posedge sdram_clk or negedge resetn) begin
        if (!resetn) begin
            rd_offset   <= '0;
            rd_buffer   <= 1'b1;
            rd_suppress <= 1'b0;
        end else begin
            if (rd_frame_start) begin
                rd_offset <= '0;
                rd_buffer <= frame_complete ? wr_buffer : ~wr_buffer;
            end else if (finish && (cmd_op == OP_RD) && !rd_suppress) begin
                rd_offset <= rd_offset + BURST;
            end
            if (launch) begin
                rd_suppress <= rd_frame_start;
            end else if (rd_frame_start) begin
                rd_suppress <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sdram_scheduler.sv
// Bench for sdram_scheduler: directed vector table, hand-written frame sequences and a
// randomized run checked every cycle against a rule-level reference model.
module tb_sdram_scheduler;
    localparam int FW     = 256;
    localparam int B      = 8;
    localparam int RI     = 375;
    localparam int LOW    = 64;
    localparam int HIGH   = 504;
    localparam int STRIDE = 18;

    logic        sdram_clk = 1'b0;
    logic        resetn = 1'b0;
    logic        init_done = 1'b1;
    logic [9:0]  wr_level = 10'd0;
    logic        wr_frame_start = 1'b0;
    logic [9:0]  rd_level = 10'd1000;
    logic        rd_frame_start = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_op;
    logic [21:0] cmd_addr;
    logic        cmd_done = 1'b0;
    logic        wr_buffer;
    logic        rd_buffer;
    logic        refresh_overrun;

    int total = 0;
    int bad = 0;
    int resp_mode = 0;   // 0 hold, 1 random, 2 fast, 3 accept but never finish

    sdram_scheduler #(
        .ADDR_WIDTH(22), .LEVEL_WIDTH(10), .BURST_LEN(B), .FRAME_WORDS(FW),
        .BUFFER_STRIDE_LOG2(STRIDE), .REFRESH_INTERVAL(RI), .RD_LOW_WM(LOW), .RD_HIGH_WM(HIGH)
    ) dut (
        .sdram_clk(sdram_clk), .resetn(resetn), .init_done(init_done),
        .wr_level(wr_level), .wr_frame_start(wr_frame_start),
        .rd_level(rd_level), .rd_frame_start(rd_frame_start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_done(cmd_done), .wr_buffer(wr_buffer), .rd_buffer(rd_buffer),
        .refresh_overrun(refresh_overrun)
    );

    always #5 sdram_clk = ~sdram_clk;

    // Reference model state: plain integers following the scheduling rules.
    int m_timer, m_pend, m_wo, m_ro, m_op, m_addr;
    bit m_ovr, m_wb, m_rb, m_fc, m_wsup, m_rsup, m_offered, m_accepted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        if (m_pend != 0) return 3;
        if (int'(rd_level) < LOW && m_ro < FW) return 2;
        if (int'(wr_level) >= B && m_wo < FW) return 1;
        if (int'(rd_level) <= HIGH && m_ro < FW) return 2;
        return 0;
    endfunction

    function automatic int addr_of(input int op);
        if (op == 1) return int'(m_wb) * (1 << STRIDE) + m_wo;
        if (op == 2) return int'(m_rb) * (1 << STRIDE) + m_ro;
        return 0;
    endfunction

    task automatic model_reset();
        m_timer = RI - 1; m_pend = 0; m_wo = 0; m_ro = 0; m_op = 0; m_addr = 0;
        m_ovr = 0; m_wb = 0; m_rb = 1; m_fc = 0; m_wsup = 0; m_rsup = 0;
        m_offered = 0; m_accepted = 0;
    endtask

    task automatic model_step();
        int op_now;
        int addr_now;
        bit fin;
        bit tick_ev;
        bit old_wb;
        bit old_fc;
        op_now = (!m_offered && !m_accepted && init_done) ? pick() : 0;
        addr_now = addr_of(op_now);
        fin = m_accepted && cmd_done;
        tick_ev = init_done && (m_timer == 0);
        m_timer = (!init_done || m_timer == 0) ? RI - 1 : m_timer - 1;
        if (tick_ev && !(fin && m_op == 3)) begin
            if (m_pend == 15) m_ovr = 1; else m_pend++;
        end else if (!tick_ev && fin && m_op == 3) begin
            m_pend--;
        end
        old_wb = m_wb;
        old_fc = m_fc;
        if (wr_frame_start) begin
            m_wo = 0;
            if (m_fc) begin m_wb = !m_wb; m_fc = 0; end
        end else if (fin && m_op == 1 && !m_wsup) begin
            m_wo += B;
            if (m_wo == FW) m_fc = 1;
        end
        if (rd_frame_start) begin
            m_ro = 0;
            m_rb = old_fc ? old_wb : !old_wb;
        end else if (fin && m_op == 2 && !m_rsup) begin
            m_ro += B;
        end
        if (op_now != 0) begin
            m_wsup = wr_frame_start; m_rsup = rd_frame_start;
        end else begin
            if (wr_frame_start) m_wsup = 1;
            if (rd_frame_start) m_rsup = 1;
        end
        if (op_now != 0) begin
            m_offered = 1; m_op = op_now; m_addr = addr_now;
        end else if (m_offered && cmd_ready) begin
            m_offered = 0; m_accepted = 1;
        end else if (fin) begin
            m_accepted = 0; m_op = 0;
        end
    endtask

    // Advance the model on every rising edge.
    always @(posedge sdram_clk) begin
        if (!resetn) model_reset(); else model_step();
    end

    // Compare every observable output with the model shortly after each edge.
    always @(posedge sdram_clk) begin
        #1;
        check("mdl_valid", 32'(cmd_valid), 32'(m_offered));
        check("mdl_op", 32'(cmd_op), 32'(m_op));
        check("mdl_addr", 32'(cmd_addr), 32'(m_addr));
        check("mdl_wr_buffer", 32'(wr_buffer), 32'(m_wb));
        check("mdl_rd_buffer", 32'(rd_buffer), 32'(m_rb));
        check("mdl_overrun", 32'(refresh_overrun), 32'(m_ovr));
    end

    task automatic tick();
        @(negedge sdram_clk);
        case (resp_mode)
            1: begin
                cmd_ready = ($urandom_range(0, 2) == 0);
                cmd_done = m_accepted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            end
            2: begin cmd_ready = 1'b1; cmd_done = m_accepted; end
            3: begin cmd_ready = 1'b1; cmd_done = 1'b0; end
            default: begin cmd_ready = 1'b0; cmd_done = 1'b0; end
        endcase
    endtask

    task automatic do_reset();
        @(negedge sdram_clk);
        resetn = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0;
        wr_frame_start = 1'b0; rd_frame_start = 1'b0; init_done = 1'b1;
        #1;
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_op", 32'(cmd_op), 32'd0);
        check("rst_addr", 32'(cmd_addr), 32'd0);
        check("rst_wr_buffer", 32'(wr_buffer), 32'd0);
        check("rst_rd_buffer", 32'(rd_buffer), 32'd1);
        check("rst_overrun", 32'(refresh_overrun), 32'd0);
        repeat (3) @(negedge sdram_clk);
        resetn = 1'b1;
    endtask

    task automatic wait_model(input int what, input int limit, input string name);
        int n = 0;
        bit hit = 0;
        while (!hit && n < limit) begin
            case (what)
                0: hit = (m_wo == FW);
                1: hit = m_accepted && (m_op == 1);
                2: hit = (m_pend == 0) && !m_offered && !m_accepted;
                3: hit = !m_offered && !m_accepted;
                4: hit = (m_wo == 64);
                default: hit = 1;
            endcase
            if (!hit) begin tick(); n++; end
        end
        check({name, "_reached"}, 32'(hit), 32'd1);
    endtask

    // Wait for the next non-refresh command offer and check it.
    task automatic expect_cmd(input int op, input int addr, input string name);
        int n = 0;
        bit got = 0;
        while (!got && n < 2000) begin
            tick(); n++;
            if (cmd_valid === 1'b1 && cmd_op !== 2'd3) got = 1;
        end
        check({name, "_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, "_op"}, 32'(cmd_op), 32'(op));
            check({name, "_addr"}, 32'(cmd_addr), 32'(addr));
        end
    endtask

    task automatic pulse(input bit w, input bit r);
        wr_frame_start = w; rd_frame_start = r;
        tick();
        wr_frame_start = 1'b0; rd_frame_start = 1'b0;
    endtask

    typedef struct {
        logic [9:0] wr;
        logic [9:0] rd;
        int         op;
        int         addr;
    } vec_t;

    vec_t tbl[11];
    int seen;

    initial begin
        tbl[0]  = '{10'd8,   10'd100,  1, 0};
        tbl[1]  = '{10'd8,   10'd100,  1, 8};
        tbl[2]  = '{10'd8,   10'd10,   2, 32'h40000};
        tbl[3]  = '{10'd7,   10'd100,  2, 32'h40008};
        tbl[4]  = '{10'd0,   10'd504,  2, 32'h40010};
        tbl[5]  = '{10'd20,  10'd505,  1, 16};
        tbl[6]  = '{10'd100, 10'd63,   2, 32'h40018};
        tbl[7]  = '{10'd100, 10'd64,   1, 24};
        tbl[8]  = '{10'd8,   10'd504,  1, 32};
        tbl[9]  = '{10'd7,   10'd505,  0, 0};
        tbl[10] = '{10'd0,   10'd1023, 0, 0};

        // First refresh appears 376 cycles after reset release.
        resp_mode = 0; wr_level = 10'd0; rd_level = 10'd1000;
        do_reset();
        repeat (375) tick();
        check("refresh_not_yet", 32'(cmd_valid), 32'd0);
        tick();
        check("refresh_valid_376", 32'(cmd_valid), 32'd1);
        check("refresh_op", 32'(cmd_op), 32'd3);
        check("refresh_addr", 32'(cmd_addr), 32'd0);
        resp_mode = 2;
        repeat (5) tick();
        check("refresh_pending_cleared", 32'(dut.refresh_pending), 32'd0);
        check("refresh_no_overrun", 32'(refresh_overrun), 32'd0);

        // Arbitration table.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            wr_level = tbl[i].wr; rd_level = tbl[i].rd;
            if (tbl[i].op == 0) begin
                seen = 0;
                repeat (12) begin tick(); if (cmd_valid === 1'b1 && cmd_op !== 2'd3) seen++; end
                check($sformatf("tbl%0d_none", i), 32'(seen), 32'd0);
            end else begin
                expect_cmd(tbl[i].op, tbl[i].addr, $sformatf("tbl%0d", i));
            end
            wr_level = 10'd0; rd_level = 10'd1000;
            wait_model(3, 50, $sformatf("tbl%0d_idle", i));
        end

        // Stalled controller: pending refreshes saturate, offered command stays stable.
        resp_mode = 0;
        do_reset();
        repeat (6010) tick();
        check("sat_pending", 32'(dut.refresh_pending), 32'd15);
        check("sat_overrun", 32'(refresh_overrun), 32'd1);
        check("sat_valid", 32'(cmd_valid), 32'd1);
        check("sat_op_stable", 32'(cmd_op), 32'd3);
        check("sat_addr_stable", 32'(cmd_addr), 32'd0);
        resp_mode = 2;
        wait_model(2, 300, "sat_drain");
        check("drain_pending", 32'(dut.refresh_pending), 32'd0);
        check("drain_overrun_sticky", 32'(refresh_overrun), 32'd1);

        // Full frame, then buffer swap for both paths.
        do_reset();
        resp_mode = 2; wr_level = 10'd8; rd_level = 10'd1000;
        wait_model(0, 3000, "frame_fill");
        wr_level = 10'd0;
        wait_model(3, 50, "frame_idle");
        pulse(1'b1, 1'b0);
        check("swap_wr_buffer", 32'(wr_buffer), 32'd1);
        pulse(1'b0, 1'b1);
        check("swap_rd_buffer", 32'(rd_buffer), 32'd0);
        rd_level = 10'd10;
        expect_cmd(2, 0, "swap_first_read");
        rd_level = 10'd1000; wr_level = 10'd8;
        expect_cmd(1, 32'h40000, "swap_first_write");
        wr_level = 10'd0;

        // Incomplete frame: restart overwrites the same buffer, in-flight write discarded.
        do_reset();
        resp_mode = 2; wr_level = 10'd8; rd_level = 10'd1000;
        wait_model(4, 1000, "partial_fill");
        resp_mode = 3;
        wait_model(1, 50, "partial_busy");
        wr_level = 10'd0;
        pulse(1'b1, 1'b0);
        check("partial_wr_buffer", 32'(wr_buffer), 32'd0);
        resp_mode = 2;
        wait_model(3, 50, "partial_done");
        wr_level = 10'd8;
        expect_cmd(1, 0, "partial_rewrite");
        wr_level = 10'd0;

        // Simultaneous frame starts with a completed frame in buffer 0.
        do_reset();
        resp_mode = 2; wr_level = 10'd8; rd_level = 10'd1000;
        wait_model(0, 3000, "both_fill");
        wr_level = 10'd0;
        wait_model(3, 50, "both_idle");
        pulse(1'b1, 1'b1);
        check("both_wr_buffer", 32'(wr_buffer), 32'd1);
        check("both_rd_buffer", 32'(rd_buffer), 32'd0);

        // Reset in the middle of a command.
        do_reset();
        resp_mode = 3; wr_level = 10'd8;
        wait_model(1, 50, "midrst_busy");
        resetn = 1'b0;
        #1;
        check("midrst_op", 32'(cmd_op), 32'd0);
        check("midrst_valid", 32'(cmd_valid), 32'd0);
        check("midrst_addr", 32'(cmd_addr), 32'd0);
        check("midrst_rd_buffer", 32'(rd_buffer), 32'd1);
        wr_level = 10'd0;

        // Randomized traffic against the model.
        do_reset();
        resp_mode = 1;
        for (int c = 0; c < 20000; c++) begin
            tick();
            if ($urandom_range(0, 15) == 0) wr_level = 10'($urandom_range(0, 24));
            if ($urandom_range(0, 15) == 0)
                rd_level = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 120))
                                                       : 10'($urandom_range(480, 600));
            wr_frame_start = ($urandom_range(0, 299) == 0);
            rd_frame_start = ($urandom_range(0, 299) == 0);
            if (init_done && $urandom_range(0, 1999) == 0) init_done = 1'b0;
            else if (!init_done && $urandom_range(0, 49) == 0) init_done = 1'b1;
        end
        wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
